// File: rtl/paddle_motion.sv
// paddle_motion: turns debounced left/right button levels into the paddle's
// horizontal position. Buttons are sampled once per frameTick. Holding a
// direction makes the paddle accelerate. The paddle is clamped inside
// [0, SCREEN_W-PADDLE_W].
module paddle_motion #(
    parameter int SCREEN_W     = 640,
    parameter int PADDLE_W     = 64,
    parameter int START_X      = 288,
    parameter int MIN_SPEED    = 2,
    parameter int MAX_SPEED    = 8,
    parameter int ACCEL_FRAMES = 4,
    parameter int X_W          = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           frameTick,
    input  logic           leftIn,
    input  logic           rightIn,
    output logic [X_W-1:0] paddleX,
    output logic           moving,
    output logic           dir,
    output logic           atLeftEdge,
    output logic           atRightEdge
);

    localparam int SPD_W  = $clog2(MAX_SPEED + 1);
    localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    localparam logic [X_W:0]      MAX_X    = (X_W+1)'(SCREEN_W - PADDLE_W);
    localparam logic [X_W-1:0]    START_XV = X_W'(START_X);
    localparam logic [SPD_W-1:0]  SPD_MIN  = SPD_W'(MIN_SPEED);
    localparam logic [SPD_W-1:0]  SPD_MAX  = SPD_W'(MAX_SPEED);
    localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVE_LEFT  = 2'd1,
        MOVE_RIGHT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [SPD_W-1:0]  speed_q, speed_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // Request decode and step arithmetic. The math is one bit wider than X_W
    // so that the clamp comparisons see the true sum or difference.
    state_t           req;
    logic             req_none;
    logic [SPD_W-1:0] step;
    logic [X_W:0]     x_ext, step_ext, sum_ext, diff_ext;

    // State registers. They load only when the next-state logic asks for it.
    // Otherwise the *_d values equal the *_q values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= START_XV;
            speed_q <= SPD_MIN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
        end
    end

    // Next state, speed ramp, and clamped position. Changes happen only on ticks.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        speed_d  = speed_q;
        hold_d   = hold_q;
        step     = SPD_MIN;
        req      = IDLE;
        req_none = 1'b1;

        if (leftIn && !rightIn) begin
            req      = MOVE_LEFT;
            req_none = 1'b0;
        end else if (rightIn && !leftIn) begin
            req      = MOVE_RIGHT;
            req_none = 1'b0;
        end

        x_ext    = {1'b0, x_q};
        step_ext = (X_W+1)'(step);
        sum_ext  = '0;
        diff_ext = '0;

        if (frameTick) begin
            if (req_none) begin
                state_d = IDLE;
                speed_d = SPD_MIN;
                hold_d  = '0;
            end else begin
                if (req != state_q) begin
                    // A new direction, either from IDLE or a reversal. Restart the ramp.
                    state_d = req;
                    speed_d = SPD_MIN;
                    hold_d  = '0;
                    step    = SPD_MIN;
                end else begin
                    // Same direction held. Step at the current speed, then ramp.
                    step = speed_q;
                    if (hold_q == HOLD_TOP) begin
                        hold_d  = '0;
                        speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                step_ext = (X_W+1)'(step);
                sum_ext  = x_ext + step_ext;
                diff_ext = x_ext - step_ext;

                if (req == MOVE_RIGHT) begin
                    x_d = (sum_ext > MAX_X) ? MAX_X[X_W-1:0] : sum_ext[X_W-1:0];
                end else begin
                    // A borrow out of the top bit means the step passed the left edge.
                    x_d = diff_ext[X_W] ? '0 : diff_ext[X_W-1:0];
                end
            end
        end
    end

    // Outputs decoded directly from the registers.
    always_comb begin
        paddleX     = x_q;
        moving      = (state_q != IDLE);
        dir         = (state_q == MOVE_RIGHT);
        atLeftEdge  = (x_q == '0);
        atRightEdge = ({1'b0, x_q} == MAX_X);
    end

endmodule

// File: tb/tb_paddle_motion.sv
// Directed testbench for paddle_motion. It uses the default parameters.
module tb_paddle_motion;

    logic       clk = 1'b0;
    logic       rst;
    logic       frameTick;
    logic       leftIn;
    logic       rightIn;
    logic [9:0] paddleX;
    logic       moving;
    logic       dir;
    logic       atLeftEdge;
    logic       atRightEdge;

    int total_cnt  = 0;
    int passed_cnt = 0;

    paddle_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frameTick  (frameTick),
        .leftIn     (leftIn),
        .rightIn    (rightIn),
        .paddleX    (paddleX),
        .moving     (moving),
        .dir        (dir),
        .atLeftEdge (atLeftEdge),
        .atRightEdge(atRightEdge)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) passed_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Issue one single-cycle frame tick with the given button levels.
    // Inputs are driven at negedge and outputs are sampled at the next negedge.
    task automatic tick(input logic l, input logic r);
        @(negedge clk);
        leftIn    = l;
        rightIn   = r;
        frameTick = 1'b1;
        @(negedge clk);
        frameTick = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int right_exp[6] = '{290, 292, 294, 296, 298, 301};
        rst = 1'b1; frameTick = 1'b0; leftIn = 1'b0; rightIn = 1'b0;

        // Reset state, checked before any clock edge.
        #1;
        check("rst_x",     32'(paddleX), 288);
        check("rst_moving", 32'(moving), 0);
        check("rst_dir",    32'(dir), 0);
        check("rst_ledge",  32'(atLeftEdge), 0);
        check("rst_redge",  32'(atRightEdge), 0);
        @(negedge clk);
        rst = 1'b0;

        // Hold right for 6 ticks. The 6th tick uses the ramped speed of 3.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1);
            check($sformatf("right_x%0d", i), 32'(paddleX), 32'(right_exp[i]));
        end
        check("right_dir",    32'(dir), 1);
        check("right_moving", 32'(moving), 1);

        // Buttons wiggling between ticks must have no effect.
        @(negedge clk); leftIn = 1'b1; rightIn = 1'b0;
        @(negedge clk); leftIn = 1'b1; rightIn = 1'b1;
        @(negedge clk); leftIn = 1'b0; rightIn = 1'b0;
        @(negedge clk);
        check("notick_x",   32'(paddleX), 301);
        check("notick_dir", 32'(dir), 1);

        // Keep holding right until the paddle clamps. The loop is bounded.
        for (int i = 0; i < 200 && paddleX != 10'd576; i++) tick(1'b0, 1'b1);
        check("clamp_x",      32'(paddleX), 576);
        check("clamp_redge",  32'(atRightEdge), 1);
        check("clamp_moving", 32'(moving), 1);
        tick(1'b0, 1'b1);
        check("pinned_x",      32'(paddleX), 576);
        check("pinned_moving", 32'(moving), 1);

        // Reversal test. 13 right ticks from reset reach x=326 with speed 5.
        pulse_reset();
        for (int i = 0; i < 13; i++) tick(1'b0, 1'b1);
        check("ramp_x", 32'(paddleX), 326);
        tick(1'b1, 1'b0);
        check("rev_x",      32'(paddleX), 324);
        check("rev_dir",    32'(dir), 0);
        check("rev_moving", 32'(moving), 1);
        // holdCnt restarted, so 4 more ticks step by 2, then the speed becomes 3.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        check("rev_hold_x", 32'(paddleX), 316);
        tick(1'b1, 1'b0);
        check("rev_ramp_x", 32'(paddleX), 313);

        // Both buttons pressed stops the paddle without moving it.
        tick(1'b1, 1'b1);
        check("both_moving", 32'(moving), 0);
        check("both_x",      32'(paddleX), 313);

        // Step down by 2 per (left, none) pair until x=1.
        for (int i = 0; i < 156; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        check("walk_x",     32'(paddleX), 1);
        check("walk_ledge", 32'(atLeftEdge), 0);
        tick(1'b1, 1'b0);
        check("lclamp_x",      32'(paddleX), 0);
        check("lclamp_ledge",  32'(atLeftEdge), 1);
        check("lclamp_moving", 32'(moving), 1);
        tick(1'b1, 1'b0);
        check("lpinned_x",     32'(paddleX), 0);
        check("lpinned_redge", 32'(atRightEdge), 0);

        // Asynchronous reset while moving: outputs recover with no clock edge.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        check("pre_arst_x", 32'(paddleX), 6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_x",      32'(paddleX), 288);
        check("arst_moving", 32'(moving), 0);
        check("arst_dir",    32'(dir), 0);
        #1 rst = 1'b0;
        tick(1'b0, 1'b1);
        check("post_arst_x",      32'(paddleX), 290);
        check("post_arst_moving", 32'(moving), 1);

        $display("%0d/%0d checks passed", passed_cnt, total_cnt);
        $finish;
    end

endmodule
